// File: rtl/clk_period_meter_pkg.sv
// Shared constants for the clock period meter: FSM encoding, default sizing
// and the parameter legality helper.
package clk_period_meter_pkg;

  localparam int CNT_W_DEF          = 28;
  localparam int TIMEOUT_CYCLES_DEF = 100_000_000;
  localparam int SYNC_STAGES_DEF    = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARM     = 2'd1;
  localparam state_t ST_MEASURE = 2'd2;

  // A timeout that fits in the counter guarantees the counters never wrap.
  function automatic logic timeout_fits(input longint timeout, input int cnt_w);
    return (timeout >= 64'sd2) && (cnt_w < 32'sd63) && (timeout < (64'sd1 <<< cnt_w));
  endfunction

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-flop
// edge detector producing single-cycle rise/fall strobes.
module sync_edge_det
  import clk_period_meter_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchronizer chain plus the previous-level flop for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_sig};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in system clock
// cycles, with back-to-back measurement and a no-edge timeout.
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  if (!timeout_fits(longint'(TIMEOUT_CYCLES), CNT_W) || (SYNC_STAGES < 32'sd2)) begin : g_param_check
    $error("clk_period_meter: TIMEOUT_CYCLES must be in [2, 2**CNT_W) and SYNC_STAGES >= 2");
  end

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             w_rise;
  logic             w_fall;
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] w_per_cnt_nx;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] w_high_cnt_nx;
  logic             r_high_flag;
  logic             w_high_flag_nx;
  logic             w_latch;
  logic             w_timeout_nx;
  logic             r_pend;
  logic [CNT_W-1:0] r_per_lat;
  logic [CNT_W-1:0] r_high_lat;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_meas_valid;
  logic             r_timeout;
  logic             r_busy;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk   (clk_100MHz),
    .i_rst_n (reset_n),
    .i_sig   (sig_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Next-state and counter update; the period counter doubles as the ARM wait counter.
  always_comb begin
    w_state_nx     = r_state;
    w_per_cnt_nx   = r_per_cnt;
    w_high_cnt_nx  = r_high_cnt;
    w_high_flag_nx = r_high_flag;
    w_latch        = 1'b0;
    w_timeout_nx   = 1'b0;
    if (!meas_en) begin
      w_state_nx     = ST_IDLE;
      w_per_cnt_nx   = '0;
      w_high_cnt_nx  = '0;
      w_high_flag_nx = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx     = ST_ARM;
          w_per_cnt_nx   = CNT_ONE;
          w_high_cnt_nx  = '0;
          w_high_flag_nx = 1'b0;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_state_nx     = ST_MEASURE;
            w_per_cnt_nx   = CNT_ONE;
            w_high_cnt_nx  = CNT_ONE;
            w_high_flag_nx = 1'b1;
          end else if (r_per_cnt == TO_VAL) begin
            w_timeout_nx = 1'b1;
            w_per_cnt_nx = CNT_ONE;
          end else begin
            w_per_cnt_nx = r_per_cnt + CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_latch        = 1'b1;
            w_per_cnt_nx   = CNT_ONE;
            w_high_cnt_nx  = CNT_ONE;
            w_high_flag_nx = 1'b1;
          end else if (r_per_cnt == TO_VAL) begin
            w_timeout_nx   = 1'b1;
            w_state_nx     = ST_ARM;
            w_per_cnt_nx   = CNT_ONE;
            w_high_cnt_nx  = '0;
            w_high_flag_nx = 1'b0;
          end else begin
            w_per_cnt_nx = r_per_cnt + CNT_ONE;
            if (r_high_flag && !w_fall) begin
              w_high_cnt_nx = r_high_cnt + CNT_ONE;
            end else begin
              w_high_cnt_nx = r_high_cnt;
            end
            if (w_fall) begin
              w_high_flag_nx = 1'b0;
            end else begin
              w_high_flag_nx = r_high_flag;
            end
          end
        end
        default: begin
          w_state_nx     = ST_IDLE;
          w_per_cnt_nx   = '0;
          w_high_cnt_nx  = '0;
          w_high_flag_nx = 1'b0;
        end
      endcase
    end
  end

  // State, counters, staged result and the outputs, which update together with meas_valid.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_per_cnt    <= '0;
      r_high_cnt   <= '0;
      r_high_flag  <= 1'b0;
      r_pend       <= 1'b0;
      r_per_lat    <= '0;
      r_high_lat   <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_per_cnt    <= w_per_cnt_nx;
      r_high_cnt   <= w_high_cnt_nx;
      r_high_flag  <= w_high_flag_nx;
      r_pend       <= w_latch;
      r_timeout    <= w_timeout_nx;
      r_busy       <= (w_state_nx != ST_IDLE);
      r_meas_valid <= r_pend & meas_en;
      if (w_latch) begin
        r_per_lat  <= r_per_cnt;
        r_high_lat <= r_high_cnt;
      end
      if (r_pend && meas_en) begin
        r_period <= r_per_lat;
        r_high   <= r_high_lat;
      end
    end
  end

  assign period_cycles = r_period;
  assign high_cycles   = r_high;
  assign meas_valid    = r_meas_valid;
  assign timeout       = r_timeout;
  assign busy          = r_busy;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a pattern model pushes expected
// results and their arrival cycle; a monitor pops and compares them.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TO    = 100;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 2;

  typedef struct {
    int per;
    int hi;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sig_in;
  logic             meas_en;
  logic [CNT_W-1:0] period_cycles;
  logic [CNT_W-1:0] high_cycles;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   texp_q[$];
  bit   model_en = 1'b0;
  bit   armed    = 1'b0;
  int   prev_hi  = 0;
  int   prev_lo  = 0;
  int   last_per = 0;
  int   last_hi  = 0;

  clk_period_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk_100MHz    (clk),
    .reset_n       (reset_n),
    .sig_in        (sig_in),
    .meas_en       (meas_en),
    .period_cycles (period_cycles),
    .high_cycles   (high_cycles),
    .meas_valid    (meas_valid),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sig_in period; its rising edge closes the previously driven period.
  task automatic drive_period(input int hi, input int lo);
    exp_t e;
    sig_in = 1'b1;
    if (model_en && armed) begin
      e.per = prev_hi + prev_lo;
      e.hi  = prev_hi;
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    armed   = model_en;
    prev_hi = hi;
    prev_lo = lo;
    repeat (hi) tick();
    sig_in = 1'b0;
    repeat (lo) tick();
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (meas_valid) begin
        chk("valid_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("period_cycles", 32'(period_cycles), 32'(e.per));
          chk("high_cycles", 32'(high_cycles), 32'(e.hi));
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
          last_per = e.per;
          last_hi  = e.hi;
        end
      end
      if (timeout) begin
        chk("timeout_expected", {31'd0, (texp_q.size() != 0)}, 32'd1);
        if (texp_q.size() != 0) begin
          chk("timeout_cycle", 32'(cyc), 32'(texp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int e_cyc;
    reset_n = 1'b0;
    sig_in  = 1'b0;
    meas_en = 1'b0;
    repeat (3) tick();
    chk("rst_period", 32'(period_cycles), 32'd0);
    chk("rst_high", 32'(high_cycles), 32'd0);
    chk("rst_valid", {31'd0, meas_valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // 10/10 then 3/17 duty, back to back
    meas_en  = 1'b1;
    model_en = 1'b1;
    tick();
    tick();
    chk("busy_enabled", {31'd0, busy}, 32'd1);
    repeat (4) drive_period(10, 10);
    repeat (3) drive_period(3, 17);

    // drop enable mid-period: the partial period is discarded
    drive_period(10, 8);
    meas_en  = 1'b0;
    model_en = 1'b0;
    armed    = 1'b0;
    tick();
    chk("busy_after_disable", {31'd0, busy}, 32'd0);
    drive_period(10, 10);
    chk("queue_drained_disable", 32'(exp_q.size()), 32'd0);

    // re-enable: first result needs two fresh rises; then varied shapes
    meas_en  = 1'b1;
    model_en = 1'b1;
    tick();
    tick();
    repeat (3) drive_period(6, 14);
    drive_period(7, 5);
    drive_period(4, 4);
    drive_period(5, 5);
    drive_period(8, 5);

    // asynchronous reset mid-measurement
    reset_n = 1'b0;
    #1;
    chk("arst_period", 32'(period_cycles), 32'd0);
    chk("arst_high", 32'(high_cycles), 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, meas_valid}, 32'd0);
    armed    = 1'b0;
    last_per = 0;
    last_hi  = 0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) drive_period(10, 10);
    meas_en  = 1'b0;
    model_en = 1'b0;
    armed    = 1'b0;
    repeat (5) tick();
    chk("queue_drained_reset", 32'(exp_q.size()), 32'd0);

    // stuck-low input in ARM: periodic timeouts, outputs hold
    meas_en  = 1'b1;
    model_en = 1'b1;
    e_cyc    = cyc;
    texp_q.push_back(e_cyc + TO + 1);
    texp_q.push_back(e_cyc + 2 * TO + 1);
    texp_q.push_back(e_cyc + 3 * TO + 1);
    repeat (320) tick();
    chk("to_arm_drained", 32'(texp_q.size()), 32'd0);
    chk("to_hold_period", 32'(period_cycles), 32'(last_per));
    chk("to_hold_high", 32'(high_cycles), 32'(last_hi));

    // single rise then silence: MEASURE timeout, back to ARM
    e_cyc = cyc;
    texp_q.push_back(e_cyc + SYNC + 1 + TO);
    texp_q.push_back(e_cyc + SYNC + 1 + 2 * TO);
    drive_period(10, 10);
    repeat (200) tick();
    chk("to_meas_drained", 32'(texp_q.size()), 32'd0);
    chk("to_meas_hold_period", 32'(period_cycles), 32'(last_per));
    chk("to_meas_hold_high", 32'(high_cycles), 32'(last_hi));
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_last_period", 32'(last_per), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 28, width of all cycle counts (covers 1 s at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000, maximum cycles to wait for a rising edge before flagging timeout.
REQ-003 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in (minimum 2).
REQ-004 clk_100MHz  input  1  system clock; the block has a single clock domain.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sig_in  input  1  asynchronous slow periodic signal to measure, e.g. a divided 2 Hz clock.
REQ-007 meas_en  input  1  level enable; measurement runs while high.
REQ-008 period_cycles  output  CNT_W  clk cycles between the last two synchronized rising edges.
REQ-009 high_cycles  output  CNT_W  clk cycles sig_in was high within that period.
REQ-010 meas_valid  output  1  one-cycle pulse when period_cycles/high_cycles update.
REQ-011 timeout  output  1  one-cycle pulse when no rising edge arrives within TIMEOUT_CYCLES.
REQ-012 busy  output  1  high in any state except IDLE.

Function
REQ-013 sig_in shall pass through SYNC_STAGES flops, then a one-flop edge detector producing rise/fall strobes.
REQ-014 FSM states: IDLE, ARM, MEASURE; IDLE->ARM when meas_en=1; any state->IDLE in the cycle after meas_en=0, aborting without meas_valid.
REQ-015 ARM: wait for rise; on rise clear counters (period counter loads 1), high flag set, go to MEASURE.
REQ-016 MEASURE: period counter increments every cycle; high counter increments while high flag set; fall clears high flag.
REQ-017 On rise in MEASURE: latch period_cycles = period count, high_cycles = high count, pulse meas_valid the following cycle, restart counters for the next period without returning to ARM (back-to-back).
REQ-018 Rise and fall strobes cannot coincide; if the high flag is still set at rise (no fall seen), high_cycles shall equal period_cycles.
REQ-019 Timeout: if the period counter (MEASURE) or a wait counter (ARM) reaches TIMEOUT_CYCLES without a rise, pulse timeout for one cycle, go to ARM, leave period_cycles/high_cycles unchanged.
REQ-020 Counters shall never wrap; TIMEOUT_CYCLES < 2**CNT_W is a parameter legality requirement (elaboration check).
REQ-021 Output registers hold their last value until the next meas_valid; meas_valid and timeout are never asserted in the same cycle.
REQ-022 Measurement latency: meas_valid asserts SYNC_STAGES+2 cycles after the sig_in rising edge that closes the period.

Reset
REQ-023 On reset_n=0: FSM=IDLE, all counters, synchronizer flops, period_cycles, high_cycles = 0; meas_valid, timeout, busy = 0.
REQ-024 Reset asserted mid-measurement shall discard the partial period; first meas_valid after release requires two fresh rising edges.

Structure
REQ-025 FSM state encoding and default CNT_W/TIMEOUT_CYCLES constants shall live in the shared board package.
REQ-026 One sub-module: sync_edge_det (synchronizer plus rise/fall strobes), reusable by other Basys3 input blocks.

Verification
REQ-027 sig_in 10 high/10 low, meas_en=1 -> second and later meas_valid show period_cycles=20, high_cycles=10, one pulse per 20 cycles.
REQ-028 sig_in 3 high/17 low -> period_cycles=20, high_cycles=3; duty change mid-run reflected on the next meas_valid.
REQ-029 TIMEOUT_CYCLES=100, sig_in stuck low in ARM -> timeout pulse every 100 cycles, no meas_valid, outputs unchanged.
REQ-030 meas_en dropped mid-period -> busy low within 1 cycle, no meas_valid; re-enable -> first result after two rises.
REQ-031 reset_n pulsed low mid-MEASURE -> all outputs 0 immediately (asynchronous), normal measurement resumes per REQ-024.
REQ-032 Default parameters, sig_in from a 2 Hz generator -> period_cycles=50_000_000, high_cycles=25_000_000.
